// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: four-requester round-robin arbiter feeding one shared
// 4-bit binary to 2-digit BCD converter with a held, timeout-guarded output.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   req[3:0]     : request lines, one per requester
//   bin_in[15:0] : operands, nibble i belongs to requester i
//   gnt[3:0]     : one-hot grant pulse, operand captured on previous edge
//   bcd_out[7:0] : registered result, [7:4] tens, [3:0] units
//   out_id[1:0]  : owner of bcd_out
//   out_valid    : result valid
//   out_ready    : consumer accept
//   busy         : not idle
//   timeout_err  : pulse when a held result is dropped

module bcd_conv_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] bin_in,
    output logic [3:0]  gnt,
    output logic [7:0]  bcd_out,
    output logic [1:0]  out_id,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] TLIM =
        (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state;
    state_t      nstate;
    logic [1:0]  ptr;
    logic [1:0]  id_q;
    logic [3:0]  bin_q;
    logic [7:0]  cnt;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        found;
    logic [7:0]  conv;
    logic        expire;

    // Round-robin search upward from ptr; 2-bit index wraps mod 4.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign conv = (bin_q < 4'd10) ? {4'h0, bin_q}
                                  : {4'h1, bin_q - 4'd10};

    // Accept has priority: expire only matters while out_ready is low.
    assign expire = (TIMEOUT != 0) && !out_ready && (cnt == TLIM);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (|req) nstate = CONV;
            CONV: nstate = HOLD;
            HOLD: if (out_ready || expire) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Output logic
    assign busy = (state != IDLE);

    // Registered datapath and output pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            id_q        <= '0;
            bin_q       <= '0;
            cnt         <= '0;
            gnt         <= '0;
            bcd_out     <= '0;
            out_id      <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            gnt         <= '0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        bin_q <= bin_in[{win, 2'b00} +: 4];
                        id_q  <= win;
                        gnt   <= 4'b0001 << win;
                    end
                end
                CONV: begin
                    bcd_out   <= conv;
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ptr       <= id_q + 2'd1;
                    end else if (expire) begin
                        out_valid   <= 1'b0;
                        ptr         <= id_q + 2'd1;
                        timeout_err <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed self-checking bench for bcd_conv_arbiter.
// Two instances share stimulus: TIMEOUT=16 (main) and TIMEOUT=4.

module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] bin_in;
    logic        out_ready;

    logic [3:0]  gnt,  gnt4;
    logic [7:0]  bcd,  bcd4;
    logic [1:0]  oid,  oid4;
    logic        ov,   ov4;
    logic        bsy,  bsy4;
    logic        terr, terr4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
        .gnt(gnt), .bcd_out(bcd), .out_id(oid), .out_valid(ov),
        .out_ready(out_ready), .busy(bsy), .timeout_err(terr)
    );

    bcd_conv_arbiter #(.TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
        .gnt(gnt4), .bcd_out(bcd4), .out_id(oid4), .out_valid(ov4),
        .out_ready(out_ready), .busy(bsy4), .timeout_err(terr4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        bin_in = '0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt, bcd, oid, ov, bsy, terr} !== 17'd0) begin
            bad++;
            $display("FAIL reset got=%h want=0",
                     {gnt, bcd, oid, ov, bsy, terr});
        end
        total++;
        if ({gnt4, bcd4, oid4, ov4, bsy4, terr4} !== 17'd0) begin
            bad++;
            $display("FAIL reset4 got=%h want=0",
                     {gnt4, bcd4, oid4, ov4, bsy4, terr4});
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        bin_in = 16'h0D00;
        out_ready = 1'b1;
        step();
        total++;
        if (gnt !== 4'b0100 || bsy !== 1'b1) begin
            bad++;
            $display("FAIL single_gnt got=%b/%b want=0100/1", gnt, bsy);
        end
        req = '0;
        step();
        total++;
        if ({gnt, ov, bcd, oid} !== {4'b0000, 1'b1, 8'h13, 2'd2}) begin
            bad++;
            $display("FAIL single_out got=%b %b %h %0d want=0000 1 13 2",
                     gnt, ov, bcd, oid);
        end
        step();
        total++;
        if ({ov, bcd, oid, bsy} !== {1'b0, 8'h13, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL single_accept got=%b %h %0d %b want=0 13 2 0",
                     ov, bcd, oid, bsy);
        end
    endtask

    task automatic test_convert();
        logic [7:0] exp_tab [16];
        exp_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                    8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11,
                    8'h12, 8'h13, 8'h14, 8'h15};
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            req = 4'b0001;
            bin_in = 16'(v);
            step();
            req = '0;
            step();
            total++;
            if (ov !== 1'b1 || bcd !== exp_tab[v] || oid !== 2'd0) begin
                bad++;
                $display("FAIL conv_%0d got=%b %h %0d want=1 %h 0",
                         v, ov, bcd, oid, exp_tab[v]);
            end
            step();
        end
    endtask

    task automatic test_fairness();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        bin_in = 16'h3210;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (gnt !== seq[i]) begin
                bad++;
                $display("FAIL fair_%0d got=%b want=%b", i, gnt, seq[i]);
            end
            if (i == 4) req = '0;
            step();
            total++;
            if (gnt !== 4'b0000) begin
                bad++;
                $display("FAIL fair_gap_%0d got=%b want=0000", i, gnt);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        req = 4'b0010;
        bin_in = 16'h0070;
        out_ready = 1'b0;
        step();
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({ov, bcd, oid, gnt} !== {1'b1, 8'h07, 2'd1, 4'b0000}) begin
                bad++;
                $display("FAIL bp_hold_%0d got=%b %h %0d %b want=1 07 1 0000",
                         i, ov, bcd, oid, gnt);
            end
        end
        req = '0;
        out_ready = 1'b1;
        step();
        total++;
        if ({ov, terr, bcd} !== {1'b0, 1'b0, 8'h07}) begin
            bad++;
            $display("FAIL bp_accept got=%b %b %h want=0 0 07", ov, terr, bcd);
        end
        step();
        total++;
        if ({ov, gnt, bsy} !== {1'b0, 4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL bp_single got=%b %b %b want=0 0000 0", ov, gnt, bsy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        bin_in = 16'h0003;
        out_ready = 1'b0;
        step();
        req = '0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (ov4 !== 1'b1 || terr4 !== 1'b0) begin
                bad++;
                $display("FAIL to_hold_%0d got=%b %b want=1 0", i, ov4, terr4);
            end
        end
        step();
        total++;
        if ({ov4, terr4, bsy4} !== {1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL to_drop got=%b %b %b want=0 1 0", ov4, terr4, bsy4);
        end
        req = 4'b0011;
        step();
        total++;
        if (terr4 !== 1'b0 || gnt4 !== 4'b0010) begin
            bad++;
            $display("FAIL to_ptr got=%b %b want=0 0010", terr4, gnt4);
        end
        req = '0;
        out_ready = 1'b1;
        step();
        step();
        req = 4'b0001;
        bin_in = 16'h0005;
        out_ready = 1'b0;
        step();
        req = '0;
        step();
        step();
        step();
        step();
        out_ready = 1'b1;
        step();
        total++;
        if ({ov4, terr4, bcd4} !== {1'b0, 1'b0, 8'h05}) begin
            bad++;
            $display("FAIL to_late_accept got=%b %b %h want=0 0 05",
                     ov4, terr4, bcd4);
        end
        step();
        total++;
        if (terr4 !== 1'b0) begin
            bad++;
            $display("FAIL to_no_err got=%b want=0", terr4);
        end
    endtask

    task automatic test_reset_hold();
        req = 4'b0100;
        bin_in = 16'h0900;
        out_ready = 1'b0;
        step();
        req = '0;
        step();
        total++;
        if (ov !== 1'b1) begin
            bad++;
            $display("FAIL rh_valid got=%b want=1", ov);
        end
        rst_n = 1'b0;
        step();
        total++;
        if ({ov, bsy, gnt, terr, bcd} !== 15'd0) begin
            bad++;
            $display("FAIL rh_clear got=%b %b %b %b %h want=0 0 0000 0 00",
                     ov, bsy, gnt, terr, bcd);
        end
        rst_n = 1'b1;
        req = 4'b1010;
        out_ready = 1'b1;
        step();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL rh_regrant got=%b want=0010", gnt);
        end
        req = '0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_convert();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
